idu_pipe: RTL and testbench

//  Registered RV64I decode stage between IFU and EXU; optional RV64M decode.

---
 rtl/idu_pipe.sv | 237 +++++++++++++++++++++++
 tb/tb_idu_pipe.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_pipe.sv
// RV64I(+M) decode stage: combinational decode of the incoming word, registered
// into an output slot backed by a one-entry skid so backpressure costs no bubbles.
module idu_pipe #(
    parameter int XLEN     = 64,
    parameter bit DECODE_M = 1'b1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_insn,
    input  logic [XLEN-1:0]  i_pc,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_insn,
    output logic [XLEN-1:0]  o_pc,
    output logic [4:0]       o_rd,
    output logic [4:0]       o_rs1_addr,
    output logic [4:0]       o_rs2_addr,
    output logic             o_rs1_re,
    output logic             o_rs2_re,
    output logic             o_rf_we,
    output logic [XLEN-1:0]  o_imm,
    output logic             o_lsu_load,
    output logic             o_lsu_store,
    output logic [3:0]       o_lsu_size,
    output logic             o_lsu_sigext,
    output logic             o_wb_sel,
    output logic             o_mul,
    output logic             o_sys,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_dec_cnt
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [31:0]     insn;
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            rs1_re;
        logic            rs2_re;
        logic            rf_we;
        logic [XLEN-1:0] imm;
        logic            load;
        logic            store;
        logic [3:0]      size;
        logic            sigext;
        logic            mul;
        logic            sys;
        logic            illegal;
    } dec_t;

    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    dec_t            dec_p0;
    dec_t            out_p1;
    dec_t            skid_p1;
    logic            vld_p1;
    logic            skid_vld_p1;
    logic [CNT_W-1:0] cnt;

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic            ok, we, r1, r2, ld, st, sx, mul, sys;
    logic [3:0]      size;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] imm_i;

    assign opc   = i_insn[6:0];
    assign f3    = i_insn[14:12];
    assign f7    = i_insn[31:25];
    assign imm_i = sext32({{20{i_insn[31]}}, i_insn[31:20]});

    // Stage p0: decode of the word currently offered by the IFU
    always_comb begin
        ok = 1'b0; we = 1'b0; r1 = 1'b0; r2 = 1'b0; ld = 1'b0; st = 1'b0;
        sx = 1'b0; mul = 1'b0; sys = 1'b0; size = 4'd0; imm = '0;
        case (opc)
            OP_LUI, OP_AUIPC: begin
                ok = 1'b1; we = 1'b1;
                imm = sext32({i_insn[31:12], 12'b0});
            end
            OP_JAL: begin
                ok = 1'b1; we = 1'b1;
                imm = sext32({{11{i_insn[31]}}, i_insn[31], i_insn[19:12], i_insn[20], i_insn[30:21], 1'b0});
            end
            OP_JALR: begin
                ok = (f3 == 3'd0); we = 1'b1; r1 = 1'b1; imm = imm_i;
            end
            OP_BRANCH: begin
                ok = (f3 != 3'd2) && (f3 != 3'd3); r1 = 1'b1; r2 = 1'b1;
                imm = sext32({{19{i_insn[31]}}, i_insn[31], i_insn[7], i_insn[30:25], i_insn[11:8], 1'b0});
            end
            OP_LOAD: begin
                ok = (f3 != 3'd7); we = 1'b1; r1 = 1'b1; ld = 1'b1; imm = imm_i;
                size = 4'd1 << f3[1:0];
                sx = ~f3[2] && (f3[1:0] != 2'd3);
            end
            OP_STORE: begin
                ok = ~f3[2]; r1 = 1'b1; r2 = 1'b1; st = 1'b1;
                size = 4'd1 << f3[1:0];
                imm = sext32({{20{i_insn[31]}}, i_insn[31:25], i_insn[11:7]});
            end
            OP_IMM: begin
                we = 1'b1; r1 = 1'b1;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    ok = (i_insn[31:26] == 6'b000000) || (f3 == 3'd5 && i_insn[31:26] == 6'b010000);
                    imm = XLEN'(i_insn[25:20]);
                end else begin
                    ok = 1'b1; imm = imm_i;
                end
            end
            OP_IMM32: begin
                we = 1'b1; r1 = 1'b1;
                if (f3 == 3'd0) begin
                    ok = 1'b1; imm = imm_i;
                end else begin
                    ok = (f3 == 3'd1 && f7 == 7'b0000000) ||
                         (f3 == 3'd5 && (f7 == 7'b0000000 || f7 == 7'b0100000));
                    imm = XLEN'(i_insn[24:20]);
                end
            end
            OP_REG: begin
                we = 1'b1; r1 = 1'b1; r2 = 1'b1; mul = (f7 == 7'b0000001);
                ok = (f7 == 7'b0000000) ||
                     (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)) ||
                     (DECODE_M && mul);
            end
            OP_REG32: begin
                we = 1'b1; r1 = 1'b1; r2 = 1'b1; mul = (f7 == 7'b0000001);
                ok = (f7 == 7'b0000000 && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) ||
                     (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)) ||
                     (DECODE_M && mul && (f3 == 3'd0 || f3[2]));
            end
            OP_FENCE: ok = (f3 == 3'd0);
            OP_SYSTEM: begin
                sys = (i_insn == 32'h0000_0073) || (i_insn == 32'h0010_0073);
                ok  = sys;
            end
            default: ok = 1'b0;
        endcase

        dec_p0      = '0;
        dec_p0.insn = i_insn;
        dec_p0.pc   = i_pc;
        if (ok) begin
            dec_p0.rd     = we ? i_insn[11:7]  : 5'd0;
            dec_p0.rs1    = r1 ? i_insn[19:15] : 5'd0;
            dec_p0.rs2    = r2 ? i_insn[24:20] : 5'd0;
            dec_p0.rs1_re = r1;
            dec_p0.rs2_re = r2;
            dec_p0.rf_we  = we;
            dec_p0.imm    = imm;
            dec_p0.load   = ld;
            dec_p0.store  = st;
            dec_p0.size   = size;
            dec_p0.sigext = sx;
            dec_p0.mul    = mul;
            dec_p0.sys    = sys;
        end else begin
            dec_p0.illegal = 1'b1;
        end
    end

    logic accept, deliver;
    assign accept  = i_valid && !skid_vld_p1 && !flush;
    assign deliver = vld_p1 && i_ready;

    // Stage p1: output slot plus skid; skid only fills while the output is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            out_p1      <= '0;
            skid_p1     <= '0;
            cnt         <= '0;
        end else begin
            if (deliver) cnt <= cnt + CNT_W'(1);
            if (flush) begin
                vld_p1      <= 1'b0;
                skid_vld_p1 <= 1'b0;
            end else if (skid_vld_p1 && (!vld_p1 || deliver)) begin
                out_p1      <= skid_p1;
                vld_p1      <= 1'b1;
                skid_vld_p1 <= 1'b0;
            end else if (!vld_p1 || deliver) begin
                vld_p1 <= accept;
                if (accept) out_p1 <= dec_p0;
            end else if (accept) begin
                skid_p1     <= dec_p0;
                skid_vld_p1 <= 1'b1;
            end
        end
    end

    assign o_ready      = ~skid_vld_p1;
    assign o_valid      = vld_p1;
    assign o_insn       = out_p1.insn;
    assign o_pc         = out_p1.pc;
    assign o_rd         = out_p1.rd;
    assign o_rs1_addr   = out_p1.rs1;
    assign o_rs2_addr   = out_p1.rs2;
    assign o_rs1_re     = out_p1.rs1_re;
    assign o_rs2_re     = out_p1.rs2_re;
    assign o_rf_we      = out_p1.rf_we;
    assign o_imm        = out_p1.imm;
    assign o_lsu_load   = out_p1.load;
    assign o_lsu_store  = out_p1.store;
    assign o_lsu_size   = out_p1.size;
    assign o_lsu_sigext = out_p1.sigext;
    assign o_wb_sel     = out_p1.load;
    assign o_mul        = out_p1.mul;
    assign o_sys        = out_p1.sys;
    assign o_illegal    = out_p1.illegal;
    assign o_dec_cnt    = cnt;

endmodule

// File: tb/tb_idu_pipe.sv
// Bench for idu_pipe: a format-driven reference decoder plus a FIFO/counter model
// checked every cycle on two instances (RV64M on with 32-bit count, off with 4-bit).
module tb_idu_pipe;

    typedef struct packed {
        logic [31:0] insn;
        logic [63:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rs1_re;
        logic        rs2_re;
        logic        rf_we;
        logic [63:0] imm;
        logic        load;
        logic        store;
        logic [3:0]  size;
        logic        sigext;
        logic        mul;
        logic        sys;
        logic        illegal;
    } dec_t;

    typedef struct {
        logic [31:0] insn;
        logic [63:0] pc;
    } ent_t;

    localparam int NX = 20;
    localparam logic [31:0] EXTRA [0:NX-1] = '{
        32'h04009093, 32'h01F0909B, 32'h4030D09B, 32'hFFDFF0EF, 32'hFE208CE3,
        32'hFFF10083, 32'h00016083, 32'h00000073, 32'h0FF0000F, 32'h30001073,
        32'h00004501, 32'h023100BB, 32'h0231E0BB, 32'h023110BB, 32'h000100E7,
        32'h80000097, 32'h00017083, 32'h00004023, 32'h00002063, 32'h40209033};

    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, i_valid = 1'b0, i_ready = 1'b0;
    logic [31:0] i_insn = '0;
    logic [63:0] i_pc = '0;
    logic [63:0] pc_next = 64'h0000_0000_8000_0000;
    int          n_checks = 0, n_fail = 0;

    logic a_ready, a_valid, a_rs1_re, a_rs2_re, a_rf_we, a_load, a_store, a_sigext, a_wb, a_mul, a_sys, a_ill;
    logic b_ready, b_valid, b_rs1_re, b_rs2_re, b_rf_we, b_load, b_store, b_sigext, b_wb, b_mul, b_sys, b_ill;
    logic [31:0] a_insn, b_insn;
    logic [63:0] a_pc, b_pc, a_imm, b_imm;
    logic [4:0]  a_rd, a_rs1, a_rs2, b_rd, b_rs1, b_rs2;
    logic [3:0]  a_size, b_size;
    logic [31:0] a_cnt;
    logic [3:0]  b_cnt;
    dec_t        act_a, act_b;

    assign act_a = {a_insn, a_pc, a_rd, a_rs1, a_rs2, a_rs1_re, a_rs2_re, a_rf_we, a_imm,
                    a_load, a_store, a_size, a_sigext, a_mul, a_sys, a_ill};
    assign act_b = {b_insn, b_pc, b_rd, b_rs1, b_rs2, b_rs1_re, b_rs2_re, b_rf_we, b_imm,
                    b_load, b_store, b_size, b_sigext, b_mul, b_sys, b_ill};

    idu_pipe #(.XLEN(64), .DECODE_M(1'b1), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .i_valid(i_valid), .o_ready(a_ready),
        .i_insn(i_insn), .i_pc(i_pc), .o_valid(a_valid), .i_ready(i_ready),
        .o_insn(a_insn), .o_pc(a_pc), .o_rd(a_rd), .o_rs1_addr(a_rs1), .o_rs2_addr(a_rs2),
        .o_rs1_re(a_rs1_re), .o_rs2_re(a_rs2_re), .o_rf_we(a_rf_we), .o_imm(a_imm),
        .o_lsu_load(a_load), .o_lsu_store(a_store), .o_lsu_size(a_size), .o_lsu_sigext(a_sigext),
        .o_wb_sel(a_wb), .o_mul(a_mul), .o_sys(a_sys), .o_illegal(a_ill), .o_dec_cnt(a_cnt));

    idu_pipe #(.XLEN(64), .DECODE_M(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .i_valid(i_valid), .o_ready(b_ready),
        .i_insn(i_insn), .i_pc(i_pc), .o_valid(b_valid), .i_ready(i_ready),
        .o_insn(b_insn), .o_pc(b_pc), .o_rd(b_rd), .o_rs1_addr(b_rs1), .o_rs2_addr(b_rs2),
        .o_rs1_re(b_rs1_re), .o_rs2_re(b_rs2_re), .o_rf_we(b_rf_we), .o_imm(b_imm),
        .o_lsu_load(b_load), .o_lsu_store(b_store), .o_lsu_size(b_size), .o_lsu_sigext(b_sigext),
        .o_wb_sel(b_wb), .o_mul(b_mul), .o_sys(b_sys), .o_illegal(b_ill), .o_dec_cnt(b_cnt));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference decode: classify into a format, then derive every field from the format.
    function automatic dec_t ref_dec(input logic [31:0] w, input logic [63:0] pc, input bit m_en);
        dec_t d;
        byte  fmt;
        int   sh;
        logic [6:0] op, f7;
        logic [2:0] f3;
        d = '0; d.insn = w; d.pc = pc;
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        fmt = "X"; sh = 0;
        case (op)
            7'h37, 7'h17: fmt = "U";
            7'h6F: fmt = "J";
            7'h67: if (f3 == 0) fmt = "I";
            7'h63: if (f3 != 2 && f3 != 3) fmt = "B";
            7'h03: if (f3 != 7) begin
                fmt = "I"; d.load = 1'b1; d.size = 4'(1 << (f3 % 4)); d.sigext = (f3 < 3);
            end
            7'h23: if (f3 < 4) begin fmt = "S"; d.store = 1'b1; d.size = 4'(1 << f3); end
            7'h13: begin
                if (f3 == 1) begin
                    if (w[31:26] == 6'h00) begin fmt = "I"; sh = 6; end
                end else if (f3 == 5) begin
                    if (w[31:26] == 6'h00 || w[31:26] == 6'h10) begin fmt = "I"; sh = 6; end
                end else fmt = "I";
            end
            7'h1B: begin
                if (f3 == 0) fmt = "I";
                else if (f3 == 1 && f7 == 0) begin fmt = "I"; sh = 5; end
                else if (f3 == 5 && (f7 == 0 || f7 == 7'h20)) begin fmt = "I"; sh = 5; end
            end
            7'h33: begin
                if (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) fmt = "R";
                else if (f7 == 1 && m_en) begin fmt = "R"; d.mul = 1'b1; end
            end
            7'h3B: begin
                if ((f7 == 0 && (f3 == 0 || f3 == 1 || f3 == 5)) || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) fmt = "R";
                else if (f7 == 1 && m_en && (f3 == 0 || f3 >= 4)) begin fmt = "R"; d.mul = 1'b1; end
            end
            7'h0F: if (f3 == 0) fmt = "N";
            7'h73: if (w == 32'h0000_0073 || w == 32'h0010_0073) begin fmt = "N"; d.sys = 1'b1; end
            default: fmt = "X";
        endcase
        if (fmt == "X") begin
            d.illegal = 1'b1;
            return d;
        end
        d.rs1_re = (fmt == "R" || fmt == "I" || fmt == "S" || fmt == "B");
        d.rs2_re = (fmt == "R" || fmt == "S" || fmt == "B");
        d.rf_we  = (fmt == "R" || fmt == "I" || fmt == "U" || fmt == "J");
        d.rd  = d.rf_we  ? w[11:7]  : 5'd0;
        d.rs1 = d.rs1_re ? w[19:15] : 5'd0;
        d.rs2 = d.rs2_re ? w[24:20] : 5'd0;
        case (fmt)
            "I": d.imm = (sh == 6) ? {58'b0, w[25:20]} : (sh == 5) ? {59'b0, w[24:20]} : {{52{w[31]}}, w[31:20]};
            "S": d.imm = {{52{w[31]}}, w[31:25], w[11:7]};
            "B": d.imm = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            "U": d.imm = {{32{w[31]}}, w[31:12], 12'b0};
            "J": d.imm = {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: d.imm = '0;
        endcase
        return d;
    endfunction

    // Per-cycle comparison against a FIFO of accepted instructions and a delivery count
    initial begin
        ent_t q[$];
        int unsigned cnt_m;
        bit acc, del;
        dec_t ea, eb;
        cnt_m = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                cnt_m = 0;
            end else begin
                chk("valid_a", a_valid, q.size() != 0);
                chk("valid_b", b_valid, q.size() != 0);
                chk("ready_a", a_ready, q.size() < 2);
                chk("ready_b", b_ready, q.size() < 2);
                chk("cnt_a", a_cnt, cnt_m);
                chk("cnt_b", b_cnt, cnt_m % 16);
                if (q.size() != 0) begin
                    ea = ref_dec(q[0].insn, q[0].pc, 1'b1);
                    eb = ref_dec(q[0].insn, q[0].pc, 1'b0);
                    chk("fields_a", act_a, ea);
                    chk("fields_b", act_b, eb);
                    chk("wbsel_a", a_wb, ea.load);
                    chk("wbsel_b", b_wb, eb.load);
                end
                acc = i_valid && (q.size() < 2) && !flush;
                del = (q.size() != 0) && i_ready;
                if (del) cnt_m++;
                if (flush) q.delete();
                else begin
                    if (del) void'(q.pop_front());
                    if (acc) q.push_back('{insn: i_insn, pc: i_pc});
                end
            end
        end
    end

    task automatic send(input logic [31:0] w);
        logic r;
        bit   done;
        done = 1'b0;
        i_valid = 1'b1; i_insn = w; i_pc = pc_next;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk); r = a_ready;
            @(posedge clk); #1;
            done = r;
        end
        i_valid = 1'b0;
        pc_next = pc_next + 64'd4;
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: insn 0x%h not accepted, want accepted within 50 cycles", w);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        chk("rst_valid", a_valid, 0);
        chk("rst_ready", a_ready, 1);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_imm", a_imm, 0);
        chk("rst_rd", a_rd, 0);
        rst = 1'b0;
        i_ready = 1'b1;

        send(32'hFFF10093);
        chk("addi_valid", a_valid, 1);
        chk("addi_rd", a_rd, 1);
        chk("addi_rs1", a_rs1, 2);
        chk("addi_rs1_re", a_rs1_re, 1);
        chk("addi_imm", a_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(1);
        chk("addi_cnt", a_cnt, 1);

        send(32'h123450B7);
        chk("lui_imm", a_imm, 64'h0000_0000_1234_5000);
        chk("lui_we", a_rf_we, 1);
        chk("lui_rs1_re", a_rs1_re, 0);
        send(32'h00833283);
        chk("ld_load", a_load, 1);
        chk("ld_size", a_size, 8);
        chk("ld_wbsel", a_wb, 1);
        idle(2);

        i_ready = 1'b0;
        send(32'h002081B3);
        send(32'h40208233);
        chk("skid_ready", a_ready, 0);
        chk("skid_head", a_insn, 32'h002081B3);
        fork
            begin repeat (3) @(posedge clk); #1 i_ready = 1'b1; end
        join_none
        send(32'h0020A223);
        chk("bp_last", a_insn, 32'h0020A223);
        chk("bp_cnt", a_cnt, 5);
        idle(3);

        i_ready = 1'b0;
        send(32'h00500393);
        send(32'h00600413);
        i_valid = 1'b1; i_insn = 32'h00700493; i_pc = pc_next; flush = 1'b1;
        idle(1);
        flush = 1'b0; i_valid = 1'b0;
        chk("flush_valid", a_valid, 0);
        chk("flush_ready", a_ready, 1);
        chk("flush_cnt", a_cnt, 6);
        send(32'h00800513);
        flush = 1'b1; i_ready = 1'b1;
        idle(1);
        flush = 1'b0;
        chk("flushdel_valid", a_valid, 0);
        chk("flushdel_cnt", a_cnt, 7);
        idle(2);

        send(32'h00000000);
        chk("zero_illegal", a_ill, 1);
        chk("zero_we", a_rf_we, 0);
        send(32'h02208033);
        chk("mul_a", a_mul, 1);
        chk("mul_a_legal", a_ill, 0);
        chk("mul_b_illegal", b_ill, 1);
        chk("mul_b_mul", b_mul, 0);
        send(32'h00100073);
        chk("ebreak_sys", a_sys, 1);
        send(32'h43F35293);
        chk("srai_imm", a_imm, 63);
        for (int i = 0; i < NX; i++) send(EXTRA[i]);
        idle(3);

        i_ready = 1'b0;
        send(32'h00100093);
        send(32'h00200113);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid_a", a_valid, 0);
        chk("arst_valid_b", b_valid, 0);
        chk("arst_ready", a_ready, 1);
        chk("arst_cnt", a_cnt, 0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        i_ready = 1'b1;

        for (int i = 0; i < 16; i++) send(EXTRA[i]);
        idle(1);
        chk("wrap_cnt_a", a_cnt, 16);
        chk("wrap_cnt_b", b_cnt, 0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
